// File: rtl/wb_defs_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes, slave FSM states
// and the burst-address wrap mask helper.
// Imported by the burst RAM slave top module.
package wb_defs;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLASSIC   = 2'd1,
        ST_BURST     = 2'd2,
        ST_WAIT_DROP = 2'd3
    } wb_state_t;

    // Low word-address bits that take part in a wrapping increment.
    // Linear bursts are handled by the caller (whole counter increments).
    function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 4'b0011;
            BTE_WRAP8:  return 4'b0111;
            BTE_WRAP16: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/wb_ram_sp.sv
// Single-port synchronous RAM with per-byte write enables.
// Latency: read data appears on rdat one cycle after re; rdat holds otherwise.
// Backpressure: none; the owner sequences accesses, a write cycle never updates rdat.
// Ports: clk/rst (rst clears only the read register), re read strobe,
//        we[3:0] byte writes (bit0 = [7:0]), addr word address, wdat, rdat.
module wb_ram_sp #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdat,
    output logic [DATA_WIDTH-1:0] rdat
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    // Write data is never forwarded: a write cycle leaves rdat untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdat <= '0;
        end else if (re && (we == 4'b0000)) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 RAM slave with classic cycles and CTI/BTE incrementing bursts.
// Latency: ack one cycle after the first request; burst beats ack every cycle with req.
// Backpressure: stb low inside a burst holds counter and data; ERR for bad/misaligned address.
// Ports: clk_i/rst_i (sync, active high), wbs_adr_i byte address, wbs_dat_i/wbs_sel_i/
//        wbs_we_i write side, wbs_stb_i/wbs_cyc_i request, wbs_cti_i/wbs_bte_i burst
//        control, wbs_dat_o read data, wbs_ack_o/wbs_err_o/wbs_rty_o terminations.
module wb_burst_ram_slave
    import wb_defs::*;
#(
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       MEM_WORDS_LOG2 = 10,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]    wbs_dat_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic                     wbs_we_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic [2:0]               wbs_cti_i,
    input  logic [1:0]               wbs_bte_i,
    output logic [DATA_WIDTH-1:0]    wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic                     wbs_rty_o
);

    typedef logic [MEM_WORDS_LOG2-1:0] word_t;

    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(4) << MEM_WORDS_LOG2;

    wb_state_t                state;
    word_t                    cnt;
    word_t                    cnt_inc;
    word_t                    cnt_nxt;
    word_t                    wrap_mask;
    word_t                    word_idx;
    word_t                    ram_addr;
    logic [ADDRESS_WIDTH-1:0] off;
    logic                     req;
    logic                     addr_ok;
    logic                     last_beat;
    logic                     beat;
    logic                     err_q;
    logic                     ram_re;
    logic [3:0]               ram_we;

    assign req       = wbs_cyc_i & wbs_stb_i;
    // Unsigned subtract: addresses below BASE_ADDR wrap high and miss.
    assign off       = wbs_adr_i - BASE_ADDR;
    assign word_idx  = off[MEM_WORDS_LOG2+1:2];
    assign addr_ok   = (off < MEM_BYTES) && (wbs_adr_i[1:0] == 2'b00);
    // Anything other than "incrementing" ends the burst (EOB, or classic mid-burst).
    assign last_beat = (wbs_cti_i != CTI_INCR);

    // Ack is qualified by the live request so master wait states and a dropped
    // cyc are honoured in the same cycle; reset suppresses the beat and its write.
    assign beat      = req & ~rst_i & ((state == ST_CLASSIC) | (state == ST_BURST));
    assign wbs_ack_o = beat;
    assign wbs_err_o = err_q;
    assign wbs_rty_o = 1'b0;

    // Burst counter advance: wrapping bursts only step the low bits.
    always_comb begin
        cnt_inc   = cnt + word_t'(1);
        wrap_mask = word_t'(bte_wrap_mask(wbs_bte_i));
        if (wbs_bte_i == BTE_LINEAR) begin
            wrap_mask = '1;
        end
        cnt_nxt = (cnt & ~wrap_mask) | (cnt_inc & wrap_mask);
    end

    // RAM port steering: first read in IDLE, writes at the counter, and in a
    // read burst a prefetch of the next word so the following beat is ready.
    always_comb begin
        ram_re   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = cnt;
        case (state)
            ST_IDLE: begin
                if (req && !err_q && addr_ok) begin
                    ram_re   = 1'b1;
                    ram_addr = word_idx;
                end
            end
            ST_CLASSIC: begin
                if (beat && wbs_we_i) begin
                    ram_we = wbs_sel_i;
                end
            end
            ST_BURST: begin
                if (beat) begin
                    if (wbs_we_i) begin
                        ram_we = wbs_sel_i;
                    end else if (!last_beat) begin
                        ram_re   = 1'b1;
                        ram_addr = cnt_nxt;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (!wbs_cyc_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // The cycle that shows ERR still has the request up;
                        // ignoring it there keeps ERR to a single cycle.
                        if (wbs_stb_i && !err_q) begin
                            if (addr_ok) begin
                                cnt   <= word_idx;
                                state <= (wbs_cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_CLASSIC: begin
                        if (wbs_stb_i) begin
                            state <= ST_WAIT_DROP;
                        end
                    end
                    ST_BURST: begin
                        if (wbs_stb_i) begin
                            cnt <= cnt_nxt;
                            if (last_beat) begin
                                state <= ST_WAIT_DROP;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    wb_ram_sp #(
        .ADDR_BITS  (MEM_WORDS_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk_i),
        .rst  (rst_i),
        .re   (ram_re),
        .we   (ram_we),
        .addr (ram_addr),
        .wdat (wbs_dat_i),
        .rdat (wbs_dat_o)
    );

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed bench for wb_burst_ram_slave: cycle-by-cycle vector table plus
// hand-written classic reads and a wrap8 burst across the block boundary.
// Inputs change 1 ns after the rising edge; outputs are compared on the falling edge.
module tb_wb_burst_ram_slave;
    import wb_defs::*;

    localparam logic [31:0] W5 = 32'h5555_0005;
    localparam logic [31:0] W6 = 32'h6666_0006;
    localparam logic [31:0] W7 = 32'h7777_0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_burst_ram_slave #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .MEM_WORDS_LOG2 (10),
        .BASE_ADDR      (32'h0000_0000)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_sel_i (sel),
        .wbs_we_i  (we),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_cti_i (cti),
        .wbs_bte_i (bte),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbs_rty_o (wbs_rty_o)
    );

    typedef struct {
        string       tag;
        bit          rst, cyc, stb, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        bit          chk;   // compare ack/err
        bit          eack, eerr;
        bit          chkd;  // compare read data
        logic [31:0] edat;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input string t, input bit r, c, s, w,
                                input logic [31:0] a, d, input logic [3:0] sl,
                                input logic [2:0] ct, input logic [1:0] bt,
                                input bit ck, ea, ee, cd, input logic [31:0] ed);
        vec_t v;
        v.tag = t; v.rst = r; v.cyc = c; v.stb = s; v.we = w;
        v.adr = a; v.dat = d; v.sel = sl; v.cti = ct; v.bte = bt;
        v.chk = ck; v.eack = ea; v.eerr = ee; v.chkd = cd; v.edat = ed;
        vq.push_back(v);
    endfunction

    function automatic void idle(input string t);
        add(t, 0, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0, 0, '0);
    endfunction

    function automatic void wr(input string t, input logic [31:0] a, d, input logic [3:0] sl,
                               input logic [2:0] ct, input logic [1:0] bt, input bit ea, ee);
        add(t, 0, 1, 1, 1, a, d, sl, ct, bt, 1, ea, ee, 0, '0);
    endfunction

    function automatic void rd(input string t, input logic [31:0] a, input logic [2:0] ct,
                               input logic [1:0] bt, input bit ea, ee, cd, input logic [31:0] ed);
        add(t, 0, 1, 1, 0, a, '0, 4'hF, ct, bt, 1, ea, ee, cd, ed);
    endfunction

    // stb low: either a master wait state (c=1) or an idle bus (c=0)
    function automatic void gap(input string t, input bit c, cd, input logic [31:0] ed);
        add(t, 0, c, 0, 0, '0, '0, 4'h0, CTI_INCR, BTE_LINEAR, 1, 0, 0, cd, ed);
    endfunction

    task automatic drive(input bit r, c, s, w, input logic [31:0] a, d,
                         input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
        rst = r; cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = sl; cti = ct; bte = bt;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic hand_read(input string t, input logic [31:0] a, input logic [31:0] exp);
        int          lat;
        bit          got;
        logic [31:0] act;
        lat = 0; got = 0; act = '0;
        @(posedge clk); #1;
        drive(0, 1, 1, 0, a, '0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1;
                act = wbs_dat_o;
                break;
            end
            lat++;
        end
        chk({t, "_lat"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'd1);
        if (got) chk({t, "_dat"}, act, exp);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w8exp [4];

        // reset
        add("rst0", 1, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0, 1, '0);
        add("rst1", 1, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0, 1, '0);
        // classic write then read; master holds stb one cycle late after ack
        wr("cw_req",  32'h10, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("cw_ack",  32'h10, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 0);
        wr("cw_hold", 32'h10, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        idle("cw_idle");
        rd("cr_req", 32'h10, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("cr_ack", 32'h10, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, 32'hDEAD_BEEF);
        idle("cr_idle");
        // byte lanes
        wr("bl_pre_req", 32'h20, 32'h1122_3344, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("bl_pre_ack", 32'h20, 32'h1122_3344, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 0);
        idle("bl_pre_idle");
        wr("bl_wr_req", 32'h20, 32'hAABB_CCDD, 4'b0101, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("bl_wr_ack", 32'h20, 32'hAABB_CCDD, 4'b0101, CTI_CLASSIC, BTE_LINEAR, 1, 0);
        idle("bl_wr_idle");
        rd("bl_rd_req", 32'h20, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("bl_rd_ack", 32'h20, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, 32'h11BB_33DD);
        idle("bl_rd_idle");
        // linear write burst words 5..7
        wr("wb_req", 32'h14, W5, 4'hF, CTI_INCR, BTE_LINEAR, 0, 0);
        wr("wb_b1",  32'h14, W5, 4'hF, CTI_INCR, BTE_LINEAR, 1, 0);
        wr("wb_b2",  32'h18, W6, 4'hF, CTI_INCR, BTE_LINEAR, 1, 0);
        wr("wb_b3",  32'h1C, W7, 4'hF, CTI_EOB,  BTE_LINEAR, 1, 0);
        idle("wb_idle");
        // wrap4 read from word 5: 5,6,7,4
        rd("w4_req", 32'h14, CTI_INCR, BTE_WRAP4, 0, 0, 0, '0);
        rd("w4_b1",  32'h14, CTI_INCR, BTE_WRAP4, 1, 0, 1, W5);
        rd("w4_b2",  32'h18, CTI_INCR, BTE_WRAP4, 1, 0, 1, W6);
        rd("w4_b3",  32'h1C, CTI_INCR, BTE_WRAP4, 1, 0, 1, W7);
        rd("w4_b4",  32'h10, CTI_EOB,  BTE_WRAP4, 1, 0, 1, 32'hDEAD_BEEF);
        gap("w4_end", 0, 1, 32'hDEAD_BEEF);
        rd("w4_cl_req", 32'h18, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("w4_cl_ack", 32'h18, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, W6);
        idle("w4_cl_idle");
        // linear read with a two-cycle master wait state after beat 2
        rd("lg_req", 32'h14, CTI_INCR, BTE_LINEAR, 0, 0, 0, '0);
        rd("lg_b1",  32'h14, CTI_INCR, BTE_LINEAR, 1, 0, 1, W5);
        rd("lg_b2",  32'h18, CTI_INCR, BTE_LINEAR, 1, 0, 1, W6);
        gap("lg_w1", 1, 0, '0);
        gap("lg_w2", 1, 0, '0);
        rd("lg_b3",  32'h1C, CTI_INCR, BTE_LINEAR, 1, 0, 1, W7);
        rd("lg_b4",  32'h20, CTI_EOB,  BTE_LINEAR, 1, 0, 1, 32'h11BB_33DD);
        gap("lg_end", 0, 1, 32'h11BB_33DD);
        // linear burst across the RAM top wraps to word 0, no ERR mid-burst
        wr("tw_pre_req", 32'hFFC, 32'h0BAD_F00D, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("tw_pre_ack", 32'hFFC, 32'h0BAD_F00D, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 0);
        idle("tw_pre_idle");
        wr("z_pre_req", 32'h0, 32'h00C0_FFEE, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("z_pre_ack", 32'h0, 32'h00C0_FFEE, 4'hF, CTI_CLASSIC, BTE_LINEAR, 1, 0);
        idle("z_pre_idle");
        rd("tw_req", 32'hFFC,  CTI_INCR, BTE_LINEAR, 0, 0, 0, '0);
        rd("tw_b1",  32'hFFC,  CTI_INCR, BTE_LINEAR, 1, 0, 1, 32'h0BAD_F00D);
        rd("tw_b2",  32'h1000, CTI_EOB,  BTE_LINEAR, 1, 0, 1, 32'h00C0_FFEE);
        gap("tw_end", 0, 1, 32'h00C0_FFEE);
        // errors: out of range read, misaligned write
        rd("er_req", 32'h1000, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("er_err", 32'h1000, CTI_CLASSIC, BTE_LINEAR, 0, 1, 0, '0);
        idle("er_idle");
        wr("ma_req", 32'h2, 32'hFFFF_FFFF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 0);
        wr("ma_err", 32'h2, 32'hFFFF_FFFF, 4'hF, CTI_CLASSIC, BTE_LINEAR, 0, 1);
        idle("ma_idle");
        rd("ma_rd_req", 32'h0, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("ma_rd_ack", 32'h0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, 32'h00C0_FFEE);
        idle("ma_rd_idle");
        // abort by cyc drop, then reset during a write burst
        rd("ab_req", 32'h10, CTI_INCR, BTE_WRAP8, 0, 0, 0, '0);
        rd("ab_b1",  32'h10, CTI_INCR, BTE_WRAP8, 1, 0, 1, 32'hDEAD_BEEF);
        gap("ab_cyc0", 0, 0, '0);
        wr("ab2_req", 32'h14, 32'h1234_5678, 4'hF, CTI_INCR, BTE_WRAP8, 0, 0);
        wr("ab2_b1",  32'h14, 32'h1234_5678, 4'hF, CTI_INCR, BTE_WRAP8, 1, 0);
        add("ab2_rst", 1, 1, 1, 1, 32'h18, 32'h9999_9999, 4'hF, CTI_INCR, BTE_WRAP8, 0, 0, 0, 0, '0);
        add("ab2_post", 0, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0, 1, '0);
        rd("ab_rd6_req", 32'h18, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("ab_rd6_ack", 32'h18, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, W6);
        idle("ab_rd6_idle");
        rd("ab_rd5_req", 32'h14, CTI_CLASSIC, BTE_LINEAR, 0, 0, 0, '0);
        rd("ab_rd5_ack", 32'h14, CTI_CLASSIC, BTE_LINEAR, 1, 0, 1, 32'h1234_5678);
        idle("ab_rd5_idle");

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            @(posedge clk); #1;
            drive(v.rst, v.cyc, v.stb, v.we, v.adr, v.dat, v.sel, v.cti, v.bte);
            @(negedge clk);
            if (v.chk) begin
                chk({v.tag, "_ack"}, 32'(wbs_ack_o), 32'(v.eack));
                chk({v.tag, "_err"}, 32'(wbs_err_o), 32'(v.eerr));
            end
            if (v.chkd) chk({v.tag, "_dat"}, wbs_dat_o, v.edat);
        end
        chk("rty_const", 32'(wbs_rty_o), 32'd0);

        // classic reads with bounded wait for ack
        hand_read("hr_top", 32'hFFC, 32'h0BAD_F00D);
        hand_read("hr_w7",  32'h1C,  W7);

        // wrap8 from word 5 wraps inside block 0..7: 5,6,7,0
        w8exp = '{32'h1234_5678, W6, W7, 32'h00C0_FFEE};
        @(posedge clk); #1;
        drive(0, 1, 1, 0, 32'h14, '0, 4'hF, CTI_INCR, BTE_WRAP8);
        @(negedge clk);
        chk("w8_req_ack", 32'(wbs_ack_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(0, 1, 1, 0, 32'h14 + 32'(4 * k), '0, 4'hF,
                  (k == 3) ? CTI_EOB : CTI_INCR, BTE_WRAP8);
            @(negedge clk);
            chk($sformatf("w8_b%0d_ack", k + 1), 32'(wbs_ack_o), 32'd1);
            chk($sformatf("w8_b%0d_dat", k + 1), wbs_dat_o, w8exp[k]);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk);
        chk("w8_end_ack", 32'(wbs_ack_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
